// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states, alignment rule.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   // Halfwords need an even byte offset; words (and the 2'b11 encoding) need offset 0.
   function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
      case (sz)
         SZ_BYTE: misaligned = 1'b0;
         SZ_HALF: misaligned = off[0];
         default: misaligned = (off != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/data_mem_be.sv
// 2^AW x 32 data memory: byte-enabled synchronous write, combinational read.
module data_mem_be #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [2**AW];

   // Write only the enabled byte lanes; contents survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: MEM/WB register, sized loads/stores with extension and
// misalignment suppression, optional multi-cycle memory latency via ex_ready.
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int AW      = 8,
   parameter int REGW    = 5,
   parameter int TAGW    = 4,
   parameter int MEM_LAT = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  logic [31:0]     ex_aluR,
   input  logic [31:0]     ex_inB,
   input  logic [REGW-1:0] ex_destR,
   input  logic            ex_wreg,
   input  logic            ex_m2reg,
   input  logic            ex_wmem,
   input  logic [1:0]      ex_size,
   input  logic            ex_unsigned,
   input  logic [TAGW-1:0] ex_ins_type,
   input  logic [TAGW-1:0] ex_ins_number,
   output logic            mem_valid,
   output logic            mem_wreg,
   output logic            mem_m2reg,
   output logic [31:0]     mem_aluR,
   output logic [31:0]     mem_mdata,
   output logic [REGW-1:0] mem_destR,
   output logic [TAGW-1:0] mem_ins_type,
   output logic [TAGW-1:0] mem_ins_number,
   output logic            mem_misalign
);

   localparam logic [2:0] LAT = 3'(MEM_LAT);

   typedef struct packed {
      logic [31:0]     alu_r;
      logic [31:0]     in_b;
      logic [REGW-1:0] dest_r;
      logic            wreg;
      logic            m2reg;
      logic            wmem;
      logic [1:0]      size;
      logic            uns;
      logic [TAGW-1:0] ins_type;
      logic [TAGW-1:0] ins_number;
   } op_t;

   // Byte lanes touched by a store of the given size at the given offset.
   function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] off);
      case (sz)
         SZ_BYTE: byte_en = 4'b0001 << off;
         SZ_HALF: byte_en = off[1] ? 4'b1100 : 4'b0011;
         default: byte_en = 4'b1111;
      endcase
   endfunction

   // Replicate store data across lanes so the byte enables pick the right copy.
   function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] data);
      case (sz)
         SZ_BYTE: store_lanes = {4{data[7:0]}};
         SZ_HALF: store_lanes = {2{data[15:0]}};
         default: store_lanes = data;
      endcase
   endfunction

   // Extract the addressed lane(s) and sign- or zero-extend to 32 bits.
   function automatic logic [31:0] load_extend(input logic [1:0] sz, input logic [1:0] off,
                                               input logic uns, input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (sz)
         SZ_BYTE: load_extend = uns ? {24'd0, b} : {{24{b[7]}}, b};
         SZ_HALF: load_extend = uns ? {16'd0, h} : {{16{h[15]}}, h};
         default: load_extend = word;
      endcase
   endfunction

   op_t             ex_op, sel_op, op_q, op_d;
   logic [0:0]      state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic            valid_q, valid_d, wreg_q, wreg_d, m2reg_q, m2reg_d;
   logic            misalign_q, misalign_d;
   logic [31:0]     alu_r_q, alu_r_d, mdata_q, mdata_d;
   logic [REGW-1:0] dest_r_q, dest_r_d;
   logic [TAGW-1:0] ins_type_q, ins_type_d, ins_number_q, ins_number_d;
   logic            accept, mem_op, mis, mem_we, finish;
   logic [31:0]     rdata;

   assign ex_op = '{alu_r: ex_aluR, in_b: ex_inB, dest_r: ex_destR, wreg: ex_wreg,
                    m2reg: ex_m2reg, wmem: ex_wmem, size: ex_size, uns: ex_unsigned,
                    ins_type: ex_ins_type, ins_number: ex_ins_number};

   // Operate on the live EX op when idle, on the parked op while waiting.
   always_comb begin
      sel_op = (state_q == ST_WAIT) ? op_q : ex_op;
      accept = (state_q == ST_IDLE) && ex_valid && !flush;
      mem_op = sel_op.m2reg || sel_op.wmem;
      mis    = mem_op && misaligned(sel_op.size, sel_op.alu_r[1:0]);
      mem_we = accept && sel_op.wmem && !mis;
   end

   data_mem_be #(.AW(AW)) u_dmem (
      .clk   (clk),
      .we    (mem_we),
      .be    (byte_en(sel_op.size, sel_op.alu_r[1:0])),
      .addr  (sel_op.alu_r[AW+1:2]),
      .wdata (store_lanes(sel_op.size, sel_op.in_b)),
      .rdata (rdata)
   );

   // FSM, wait counter and MEM/WB next values; anything not finishing is a bubble.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      op_d         = op_q;
      finish       = 1'b0;
      valid_d      = 1'b0;
      wreg_d       = 1'b0;
      m2reg_d      = 1'b0;
      misalign_d   = 1'b0;
      alu_r_d      = 32'd0;
      mdata_d      = 32'd0;
      dest_r_d     = '0;
      ins_type_d   = '0;
      ins_number_d = '0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (mem_op && (LAT != 3'd0)) begin
                  op_d    = ex_op;
                  cnt_d   = LAT;
                  state_d = ST_WAIT;
               end else begin
                  finish = 1'b1;
               end
            end
         end
         default: begin
            if (flush) begin
               state_d = ST_IDLE;
               cnt_d   = 3'd0;
            end else if (cnt_q == 3'd1) begin
               finish  = 1'b1;
               state_d = ST_IDLE;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
      endcase
      if (finish) begin
         valid_d      = 1'b1;
         alu_r_d      = sel_op.alu_r;
         dest_r_d     = sel_op.dest_r;
         ins_type_d   = sel_op.ins_type;
         ins_number_d = sel_op.ins_number;
         if (mis) begin
            misalign_d = 1'b1;
         end else begin
            wreg_d  = sel_op.wreg;
            m2reg_d = sel_op.m2reg;
            mdata_d = sel_op.m2reg ? load_extend(sel_op.size, sel_op.alu_r[1:0],
                                                 sel_op.uns, rdata) : 32'd0;
         end
      end
   end

   // Control state and MEM/WB register, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 3'd0;
         valid_q      <= 1'b0;
         wreg_q       <= 1'b0;
         m2reg_q      <= 1'b0;
         misalign_q   <= 1'b0;
         alu_r_q      <= 32'd0;
         mdata_q      <= 32'd0;
         dest_r_q     <= '0;
         ins_type_q   <= '0;
         ins_number_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         valid_q      <= valid_d;
         wreg_q       <= wreg_d;
         m2reg_q      <= m2reg_d;
         misalign_q   <= misalign_d;
         alu_r_q      <= alu_r_d;
         mdata_q      <= mdata_d;
         dest_r_q     <= dest_r_d;
         ins_type_q   <= ins_type_d;
         ins_number_q <= ins_number_d;
      end
   end

   // Parked op for multi-cycle accesses; pure data, no reset needed.
   always_ff @(posedge clk) begin
      op_q <= op_d;
   end

   assign ex_ready       = (state_q == ST_IDLE);
   assign mem_valid      = valid_q;
   assign mem_wreg       = wreg_q;
   assign mem_m2reg      = m2reg_q;
   assign mem_misalign   = misalign_q;
   assign mem_aluR       = alu_r_q;
   assign mem_mdata      = mdata_q;
   assign mem_destR      = dest_r_q;
   assign mem_ins_type   = ins_type_q;
   assign mem_ins_number = ins_number_q;

endmodule
